// File: rtl/instruction_loader.sv
// Program-store writer: takes a header/instruction/checksum byte stream and
// packs it into 32-bit words. The sequencer reads those words through a registered port.
module instruction_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [31:0]       fetch_instr,
    output logic [ADDR_W:0]   loaded_count,
    output logic              busy,
    output logic              load_done,
    output logic              load_error
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [7:0]      DEPTH_B = 8'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    logic [2:0]        state;
    logic [ADDR_W:0]   word_total;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        byte_idx;
    logic [7:0]        checksum;
    logic [23:0]       word_shift;
    logic [31:0]       mem [DEPTH];
    logic              accept;
    logic              word_write;
    logic [ADDR_W:0]   count_next;

    assign busy       = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
    assign byte_ready = busy;
    assign load_done  = (state == S_DONE);
    assign load_error = (state == S_ERR);
    assign accept     = byte_valid && byte_ready;
    assign word_write = (state == S_DATA) && accept && (byte_idx == 2'd3);
    assign count_next = loaded_count + CNT_ONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            word_total   <= '0;
            wr_addr      <= '0;
            byte_idx     <= '0;
            checksum     <= '0;
            word_shift   <= '0;
            loaded_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (load_start) state <= S_HDR;
                end
                S_HDR: begin
                    if (accept) begin
                        // A rejected header still starts a fresh (empty) session count.
                        loaded_count <= '0;
                        if ((byte_data == 8'd0) || (byte_data > DEPTH_B)) begin
                            state <= S_ERR;
                        end else begin
                            word_total <= byte_data[ADDR_W:0];
                            wr_addr    <= '0;
                            byte_idx   <= '0;
                            checksum   <= '0;
                            state      <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        checksum <= checksum + byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            wr_addr      <= wr_addr + ADDR_W'(1);
                            loaded_count <= count_next;
                            if (count_next == word_total) state <= S_CSUM;
                        end else begin
                            word_shift <= {word_shift[15:0], byte_data};
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) state <= (byte_data == checksum) ? S_DONE : S_ERR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read returns the pre-write word when fetch_addr hits the word being written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            fetch_instr <= '0;
        end else begin
            if (word_write) mem[wr_addr] <= {word_shift, byte_data};
            fetch_instr <= mem[fetch_addr];
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: the driver pushes expected reads and session
// results, and a monitor pops and compares them whenever the DUT presents them.
module tb_instruction_loader;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        logic       done;
        logic       err;
        logic [5:0] cnt;
    } sess_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic [4:0]  fetch_addr = 5'd0;
    logic [31:0] fetch_instr;
    logic [5:0]  loaded_count;
    logic        busy;
    logic        load_done;
    logic        load_error;

    int          checks = 0;
    int          failures = 0;
    logic        rd_req = 1'b0;
    int          rd_fixed = -1;
    logic [31:0] model_mem [32];
    logic [31:0] exp_reads [$];
    sess_t       exp_sess [$];

    instruction_loader #(.DEPTH(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_start   (load_start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .fetch_addr   (fetch_addr),
        .fetch_instr  (fetch_instr),
        .loaded_count (loaded_count),
        .busy         (busy),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportMissing(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=unexpected_output expected=none t=%0t", name, $time);
    endtask

    // Monitor: reads complete one edge after request; a session completes when busy falls.
    logic mon_rq;
    logic mon_prev_busy = 1'b0;
    always @(posedge clk) begin
        mon_rq = rd_req;
        #1;
        if (mon_rq) begin
            if (exp_reads.size() == 0) reportMissing("read_queue_empty");
            else checkOutput("fetch_instr", fetch_instr, exp_reads.pop_front());
        end
        if (!reset_n) begin
            mon_prev_busy = 1'b0;
        end else begin
            if (mon_prev_busy && !busy) begin
                if (exp_sess.size() == 0) begin
                    reportMissing("session_queue_empty");
                end else begin
                    sess_t e;
                    e = exp_sess.pop_front();
                    checkOutput("sess_done", load_done, e.done);
                    checkOutput("sess_error", load_error, e.err);
                    checkOutput("sess_count", loaded_count, e.cnt);
                    checkOutput("sess_ready", byte_ready, 1'b0);
                end
            end
            mon_prev_busy = busy;
        end
    end

    task automatic tick(input logic v, input logic [7:0] d, input logic st);
        @(negedge clk);
        byte_valid = v;
        byte_data  = v ? d : 8'($urandom);
        load_start = st;
        fetch_addr = (rd_fixed >= 0) ? 5'(rd_fixed) : 5'($urandom_range(0, 31));
        exp_reads.push_back(model_mem[fetch_addr]);
        rd_req = 1'b1;
        @(posedge clk);
    endtask

    // Sends byte i of a session; the last byte of each 4-byte group lands in the model memory.
    task automatic sendByte(input byte_q_t b, input int i);
        int n;
        n = int'(b[0]);
        tick(1'b1, b[i], 1'b0);
        if (n >= 1 && n <= 32 && i >= 4 && i <= 4 * n && (i % 4) == 0)
            model_mem[i / 4 - 1] = {b[i-3], b[i-2], b[i-1], b[i]};
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) tick(1'b0, 8'd0, 1'b0);
    endtask

    task automatic applyStimulus(input byte_q_t b, input int gap, input bit stray);
        sess_t e;
        int    n;
        logic [7:0] sum;
        n = int'(b[0]);
        if (n == 0 || n > 32) begin
            e.done = 1'b0;
            e.err  = 1'b1;
            e.cnt  = 6'd0;
        end else begin
            sum = 8'd0;
            for (int i = 1; i <= 4 * n; i++) sum = sum + b[i];
            e.done = (b[4*n+1] == sum);
            e.err  = (b[4*n+1] != sum);
            e.cnt  = 6'(n);
        end
        exp_sess.push_back(e);
        tick(1'b0, 8'd0, 1'b1);
        #1;
        checkOutput("busy_after_start", busy, 1'b1);
        checkOutput("ready_after_start", byte_ready, 1'b1);
        for (int i = 0; i < b.size(); i++) begin
            if (i > 0) idle(gap);
            if (stray && i == 2) tick(1'b0, 8'd0, 1'b1);
            sendByte(b, i);
        end
        idle(1);
    endtask

    task automatic checkReset();
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_ready", byte_ready, 1'b0);
        checkOutput("rst_done", load_done, 1'b0);
        checkOutput("rst_error", load_error, 1'b0);
        checkOutput("rst_count", loaded_count, 6'd0);
        checkOutput("rst_instr", fetch_instr, 32'd0);
    endtask

    initial begin
        byte_q_t nominal, badsum, reload, s;
        int n;
        logic [7:0] sum;

        for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
        nominal = '{8'h02, 8'h2F, 8'h20, 8'h00, 8'h00, 8'h30, 8'h44, 8'h00, 8'h00, 8'hC3};
        badsum  = '{8'h02, 8'h2F, 8'h20, 8'h00, 8'h00, 8'h30, 8'h44, 8'h00, 8'h00, 8'hC4};
        reload  = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};

        #1;
        checkReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] nominal load");
        applyStimulus(nominal, 0, 1'b0);
        for (int a = 0; a < 3; a++) begin
            rd_fixed = a;
            idle(1);
        end
        rd_fixed = -1;

        $display("[TB] bad checksum");
        applyStimulus(badsum, 0, 1'b0);
        rd_fixed = 1;
        idle(1);
        rd_fixed = -1;

        $display("[TB] bad headers");
        applyStimulus('{8'h00}, 0, 1'b0);
        applyStimulus('{8'h33}, 0, 1'b0);
        for (int a = 0; a < 3; a++) begin
            rd_fixed = a;
            idle(1);
        end
        rd_fixed = -1;

        $display("[TB] gaps and stray start");
        applyStimulus(nominal, 3, 1'b1);

        $display("[TB] reset mid-session");
        tick(1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 6; i++) sendByte(nominal, i);
        @(negedge clk);
        rd_req     = 1'b0;
        byte_valid = 1'b0;
        load_start = 1'b0;
        reset_n    = 1'b0;
        #1;
        checkReset();
        for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rd_fixed = a;
            idle(1);
        end
        rd_fixed = -1;
        applyStimulus(nominal, 0, 1'b0);

        $display("[TB] reload with read-during-write");
        rd_fixed = 0;
        applyStimulus(reload, 0, 1'b0);
        idle(1);
        rd_fixed = 1;
        idle(1);
        rd_fixed = -1;

        $display("[TB] randomized sessions");
        for (int r = 0; r < 8; r++) begin
            s = {};
            n = (r == 5) ? 32 : int'($urandom_range(1, 8));
            s.push_back(8'(n));
            sum = 8'd0;
            for (int i = 0; i < 4 * n; i++) begin
                s.push_back(8'($urandom));
                sum = sum + s[s.size()-1];
            end
            s.push_back(($urandom_range(0, 3) == 0) ? sum + 8'd1 : sum);
            applyStimulus(s, int'($urandom_range(0, 2)), 1'b0);
            idle(int'($urandom_range(0, 3)));
        end
        for (int r = 0; r < 2; r++) begin
            s = {};
            s.push_back(8'($urandom_range(33, 255)));
            applyStimulus(s, 0, 1'b0);
        end
        for (int a = 0; a < 32; a++) begin
            rd_fixed = a;
            idle(1);
        end
        rd_fixed = -1;

        @(negedge clk);
        rd_req     = 1'b0;
        byte_valid = 1'b0;
        load_start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reads_left", 32'(exp_reads.size()), 32'd0);
        checkOutput("sessions_left", 32'(exp_sess.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

- Writer side of the processor's program store.
- Accepts a byte stream over a valid/ready handshake: a length header, instruction bytes, then a checksum.
- Assembles the bytes into 32-bit instruction words and writes them into an internal program memory.
- The instruction fetch/sequencer reads that memory through a registered read port, so programs are loaded at run time instead of hard-coded in the sequencer's case table.

## Interface

Parameters:
- DEPTH, 32, number of 32-bit instruction words stored.
- ADDR_W, 5, address width; equals clog2(DEPTH).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle request to begin a load session.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- fetch_addr  in  ADDR_W  instruction read address from the sequencer.
- fetch_instr  out  32  registered read data.
- loaded_count  out  ADDR_W+1  words written in the current or last session.
- busy  out  1  session in progress (states HDR, DATA, CSUM).
- load_done  out  1  session completed with a correct checksum.
- load_error  out  1  session aborted.

## Operation

- A byte is accepted when byte_valid && byte_ready.
- byte_ready = busy.
- FSM states:
  - IDLE: reset state. load_start -> HDR.
  - HDR: accepted byte is N, the word count.
    - N == 0 or N > DEPTH -> ERR.
    - Otherwise store N, clear word address, byte index, checksum and loaded_count, then -> DATA.
  - DATA: bytes arrive MSB first (byte 0 = instr[31:24], which carries the opcode).
    - A 2-bit byte index counts bytes within a word.
    - On the 4th byte, write mem[wr_addr] <= {b0,b1,b2,b3}, increment wr_addr and loaded_count.
    - After word N is written -> CSUM.
  - CSUM: accepted byte is compared with the 8-bit sum (mod 256) of all 4N instruction bytes. The header is not included.
    - Match -> DONE.
    - Mismatch -> ERR.
  - DONE: load_done = 1. load_start -> HDR.
  - ERR: load_error = 1. load_start -> HDR.
- load_start is ignored in HDR, DATA and CSUM.
- On the transition to HDR, load_done and load_error clear.
- Words written before an error stay in memory. loaded_count reports how many were written.
- Memory entries not written in a session keep their previous contents.
- The read port operates in every state, including during a load.
- Read-during-write to the same address returns the old word.

## Timing

- Reset (asynchronous assert, synchronous release):
  - state = IDLE.
  - All memory words = 0 (opcode 000, NOP).
  - fetch_instr = 0, loaded_count = 0.
  - busy = 0, load_done = 0, load_error = 0, byte_ready = 0.
- Reset asserted mid-session aborts it immediately; the memory is cleared.
- load_start at edge k -> busy and byte_ready high after edge k.
- Read latency is 1 cycle: fetch_addr sampled at edge k -> fetch_instr valid after edge k.
- A word written at edge k is readable with fetch_addr presented for edge k+1 or later.
- A checksum byte accepted at edge k -> load_done (or load_error) high after edge k. busy is low the same cycle.
- A bad header accepted at edge k -> load_error after edge k.
- The loader never stalls: one byte per cycle is sustained. Gaps in byte_valid simply hold state.
- loaded_count saturates at N ≤ DEPTH. There is no wrap-around because a header > DEPTH is rejected.

## Test plan

- Nominal load:
  - Stimulus: load_start; bytes 02, 2F,20,00,00, 30,44,00,00, C3.
  - Required response:
    - load_done = 1, loaded_count = 2.
    - fetch_addr 0 -> 0x2F200000; 1 -> 0x30440000; 2 -> 0x00000000.
- Bad checksum:
  - Stimulus: same stream with final byte C4.
  - Required response:
    - load_error = 1, load_done = 0, loaded_count = 2, busy = 0.
    - Address 1 still reads 0x30440000.
- Bad header:
  - Stimulus: header 00, then separately header 33 (51 > 32).
  - Required response:
    - load_error after the header byte, byte_ready = 0.
    - loaded_count = 0, memory unchanged.
- Backpressure and gaps:
  - Stimulus: nominal stream with byte_valid low for 3 cycles between every byte; additionally load_start pulsed during DATA.
  - Required response: identical result to the nominal case; the stray load_start is ignored.
- Reset mid-session:
  - Stimulus: reset_n low after 6 accepted bytes.
  - Required response:
    - Immediately: IDLE, all outputs 0.
    - Every address reads 0.
    - A subsequent nominal load succeeds.
- Reload and read-during-write:
  - Stimulus:
    - After a nominal load, run a second session: 01, 11,22,33,44, AA.
    - Hold fetch_addr = 0 through the write edge.
  - Required response:
    - fetch_instr shows 0x2F200000 on the write cycle and 0x11223344 on the next.
    - Address 1 keeps 0x30440000.
    - load_done = 1, loaded_count = 1.
